// File: rtl/col_pkt_pkg.sv
// Shared constants, defaults and FSM encoding for the column stream packetizer.
package col_pkt_pkg;

   localparam logic [7:0] SOF            = 8'hA5;
   localparam int         PKT_WORDS_DEF  = 8;
   localparam int         FIFO_DEPTH_DEF = 16;
   localparam int         TIMEOUT_DEF    = 256;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR0,
      ST_HDR1,
      ST_HDR2,
      ST_PAY,
      ST_TRL
   } state_e;

endpackage

// File: rtl/col_word_fifo.sv
// Word FIFO with registered level/flags and first-word fall-through read data.
module col_word_fifo #(
   parameter int DEPTH = 16,
   parameter int W     = 16,
   localparam int AW   = $clog2(DEPTH),
   localparam int LW   = AW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr_en,
   input  logic [W-1:0]  wr_dat,
   input  logic          rd_en,
   output logic [W-1:0]  rd_dat,
   output logic [LW-1:0] level,
   output logic          full,
   output logic          empty
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          full_q, full_d;
   logic          empty_q, empty_d;
   logic          do_wr, do_rd;

   // Writes and reads are qualified by the flags as registered before the edge.
   assign do_wr  = wr_en & ~full_q;
   assign do_rd  = rd_en & ~empty_q;
   assign rd_dat = mem_q[rd_ptr_q];
   assign level  = level_q;
   assign full   = full_q;
   assign empty  = empty_q;

   always_comb begin
      wr_ptr_d = do_wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = do_rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
      level_d  = level_q + LW'(do_wr) - LW'(do_rd);
      full_d   = (level_d == LW'(DEPTH));
      empty_d  = (level_d == '0);
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem_q[wr_ptr_q] <= wr_dat;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

endmodule

// File: rtl/col_stream_packetizer.sv
// Buffers encoded column words and frames them as header/payload/trailer packets.
module col_stream_packetizer
   import col_pkt_pkg::*;
#(
   parameter int PKT_WORDS  = PKT_WORDS_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
   parameter int TIMEOUT    = TIMEOUT_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] in_dat,
   input  logic        in_valid,
   input  logic [31:0] tik_tok,
   output logic [15:0] out_dat,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_last,
   output logic [7:0]  drop_cnt
);

   localparam int LW = $clog2(FIFO_DEPTH) + 1;
   localparam int TW = $clog2(TIMEOUT) + 1;

   state_e        state_q, state_d;
   logic          out_valid_q, out_valid_d;
   logic [15:0]   out_dat_q, out_dat_d;
   logic          out_last_q, out_last_d;
   logic [7:0]    seq_q, seq_d;
   logic          ovf_q, ovf_d;
   logic [7:0]    drop_cnt_q, drop_cnt_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [7:0]    nwords_q, nwords_d;
   logic [7:0]    cnt_q, cnt_d;
   logic [31:0]   ts_q, ts_d;

   logic [15:0]   fifo_rd_dat;
   logic [LW-1:0] fifo_level;
   logic          fifo_full, fifo_empty, fifo_rd;
   logic          drop, accept, enough;

   col_word_fifo #(.DEPTH(FIFO_DEPTH), .W(16)) u_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .wr_en  (in_valid),
      .wr_dat (in_dat),
      .rd_en  (fifo_rd),
      .rd_dat (fifo_rd_dat),
      .level  (fifo_level),
      .full   (fifo_full),
      .empty  (fifo_empty)
   );

   assign drop      = in_valid & fifo_full;
   assign accept    = out_valid_q & out_ready;
   assign enough    = (int'(fifo_level) >= PKT_WORDS);
   assign out_dat   = out_dat_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign drop_cnt  = drop_cnt_q;

   // The next output word is computed on each acceptance so out_valid never bubbles.
   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q;
      out_dat_d   = out_dat_q;
      out_last_d  = out_last_q;
      seq_d       = seq_q;
      ovf_d       = ovf_q;
      drop_cnt_d  = drop_cnt_q;
      tmo_d       = '0;
      nwords_d    = nwords_q;
      cnt_d       = cnt_q;
      ts_d        = ts_q;
      fifo_rd     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty && (enough || tmo_q == TW'(TIMEOUT - 1))) begin
               state_d     = ST_HDR0;
               nwords_d    = enough ? 8'(PKT_WORDS) : 8'(fifo_level);
               ts_d        = tik_tok;
               out_valid_d = 1'b1;
               out_dat_d   = {SOF, seq_q};
               out_last_d  = 1'b0;
            end else if (!fifo_empty) begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         ST_HDR0: if (accept) begin
            state_d   = ST_HDR1;
            out_dat_d = ts_q[31:16];
         end
         ST_HDR1: if (accept) begin
            state_d   = ST_HDR2;
            out_dat_d = ts_q[15:0];
         end
         ST_HDR2: if (accept) begin
            state_d   = ST_PAY;
            out_dat_d = fifo_rd_dat;
            fifo_rd   = 1'b1;
            cnt_d     = 8'd1;
         end
         ST_PAY: if (accept) begin
            if (cnt_q == nwords_q) begin
               state_d    = ST_TRL;
               out_dat_d  = {ovf_q, 7'b0, nwords_q};
               out_last_d = 1'b1;
            end else begin
               out_dat_d = fifo_rd_dat;
               fifo_rd   = 1'b1;
               cnt_d     = cnt_q + 8'd1;
            end
         end
         ST_TRL: if (accept) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            out_dat_d   = '0;
            out_last_d  = 1'b0;
            seq_d       = seq_q + 8'd1;
            ovf_d       = 1'b0;
            cnt_d       = '0;
         end
         default: state_d = ST_IDLE;
      endcase
      // A drop is recorded after the trailer clear so it survives into the next packet.
      if (drop) begin
         ovf_d = 1'b1;
         if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         out_valid_q <= 1'b0;
         out_dat_q   <= '0;
         out_last_q  <= 1'b0;
         seq_q       <= '0;
         ovf_q       <= 1'b0;
         drop_cnt_q  <= '0;
         tmo_q       <= '0;
         nwords_q    <= '0;
         cnt_q       <= '0;
         ts_q        <= '0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         out_dat_q   <= out_dat_d;
         out_last_q  <= out_last_d;
         seq_q       <= seq_d;
         ovf_q       <= ovf_d;
         drop_cnt_q  <= drop_cnt_d;
         tmo_q       <= tmo_d;
         nwords_q    <= nwords_d;
         cnt_q       <= cnt_d;
         ts_q        <= ts_d;
      end
   end

endmodule

// File: tb/tb_col_stream_packetizer.sv
// Self-checking bench for col_stream_packetizer: table-driven packets plus stall, overflow, reset and sequence-wrap cases.
module tb_col_stream_packetizer;

   localparam int TIMEOUT = 256;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] in_dat;
   logic        in_valid;
   logic [31:0] tik_tok;
   logic [15:0] out_dat;
   logic        out_valid;
   logic        out_ready;
   logic        out_last;
   logic [7:0]  drop_cnt;

   col_stream_packetizer #(.PKT_WORDS(8), .FIFO_DEPTH(16), .TIMEOUT(TIMEOUT)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_dat    (in_dat),
      .in_valid  (in_valid),
      .tik_tok   (tik_tok),
      .out_dat   (out_dat),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .drop_cnt  (drop_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          nwr;
      logic [15:0] base;
      logic [31:0] ts;
      logic [15:0] exp_hdr0;
      logic [15:0] exp_trl;
   } vec_t;

   typedef struct {
      logic [15:0] dat;
      logic        last;
      int          cyc;
   } cap_t;

   int   checks = 0;
   int   errors = 0;
   int   trl_seen = 0;
   int   exp_trl = 0;
   int   cyc_cnt = 0;
   bit   toggle_mode = 1'b0;
   cap_t cap_q[$];
   vec_t vecs[5];

   bit          stall_prev = 1'b0;
   logic [15:0] prev_dat;
   logic        prev_last;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: records accepted words and checks hold-while-stalled and idle-zero behaviour.
   always @(negedge clk) begin
      cyc_cnt++;
      if (rst_n) begin
         if (!out_valid) checkOutput("idle_zero", {15'h0, out_last, out_dat}, 32'h0);
         if (stall_prev) begin
            checkOutput("stall_valid", {31'h0, out_valid}, 32'h1);
            checkOutput("stall_dat", {16'h0, out_dat}, {16'h0, prev_dat});
            checkOutput("stall_last", {31'h0, out_last}, {31'h0, prev_last});
         end
         if (out_valid && out_ready) begin
            cap_q.push_back('{out_dat, out_last, cyc_cnt});
            if (out_last) trl_seen++;
         end
         stall_prev = out_valid && !out_ready;
         prev_dat   = out_dat;
         prev_last  = out_last;
      end else begin
         stall_prev = 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (toggle_mode) out_ready = ~out_ready;
   endtask

   task automatic writeWords(input int n, input logic [15:0] base);
      for (int i = 0; i < n; i++) begin
         in_dat   = base + 16'(i);
         in_valid = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      in_dat   = '0;
   endtask

   task automatic applyStimulus(input vec_t v);
      tik_tok = v.ts;
      writeWords(v.nwr, v.base);
   endtask

   task automatic waitTrailers(input int target, input int budget);
      int c = 0;
      while (trl_seen < target && c < budget) begin
         tick();
         c++;
      end
      checkOutput("trailer_wait", {31'h0, (trl_seen >= target)}, 32'h1);
      tick();
      tick();
   endtask

   task automatic checkPacket(input string tag, input logic [15:0] hdr0, input logic [31:0] ts,
                              input logic [15:0] base, input int n, input logic [15:0] trl,
                              input bit contig);
      int   len = n + 4;
      int   first_cyc = 0;
      cap_t w;
      logic [15:0] e;
      checkOutput({tag, "_len_ok"}, {31'h0, (cap_q.size() >= len)}, 32'h1);
      if (cap_q.size() >= len) begin
         for (int i = 0; i < len; i++) begin
            w = cap_q.pop_front();
            if (i == 0)            e = hdr0;
            else if (i == 1)       e = ts[31:16];
            else if (i == 2)       e = ts[15:0];
            else if (i < len - 1)  e = base + 16'(i - 3);
            else                   e = trl;
            if (i == 0) first_cyc = w.cyc;
            checkOutput($sformatf("%s_w%0d", tag, i), {15'h0, w.last, w.dat},
                        {15'h0, (i == len - 1), e});
            if (contig && i == len - 1)
               checkOutput({tag, "_contig"}, 32'(w.cyc - first_cyc), 32'(len - 1));
         end
      end else begin
         cap_q.delete();
      end
   endtask

   initial begin
      vecs[0] = '{8, 16'h0001, 32'h12345678, 16'hA500, 16'h0008};
      vecs[1] = '{3, 16'h0100, 32'hCAFEBABE, 16'hA501, 16'h0003};
      vecs[2] = '{1, 16'hBEEF, 32'h00000001, 16'hA502, 16'h0001};
      vecs[3] = '{8, 16'hFFF8, 32'hFFFF0000, 16'hA503, 16'h0008};
      vecs[4] = '{5, 16'h0A0A, 32'h87654321, 16'hA504, 16'h0005};

      rst_n     = 1'b0;
      in_dat    = '0;
      in_valid  = 1'b0;
      tik_tok   = '0;
      out_ready = 1'b1;
      #12;
      checkOutput("rst_valid", {31'h0, out_valid}, 32'h0);
      checkOutput("rst_dat", {16'h0, out_dat}, 32'h0);
      checkOutput("rst_last", {31'h0, out_last}, 32'h0);
      checkOutput("rst_drop", {24'h0, drop_cnt}, 32'h0);
      tick();
      rst_n = 1'b1;
      tick();

      for (int v = 0; v < 5; v++) begin
         applyStimulus(vecs[v]);
         exp_trl++;
         waitTrailers(exp_trl, TIMEOUT + 100);
         checkPacket($sformatf("vec%0d", v), vecs[v].exp_hdr0, vecs[v].ts, vecs[v].base,
                     int'(vecs[v].exp_trl[7:0]), vecs[v].exp_trl, 1'b1);
      end

      // Overflow while the sink is stalled.
      out_ready = 1'b0;
      tik_tok   = 32'h11112222;
      writeWords(20, 16'h0001);
      checkOutput("ovf_drop_cnt", {24'h0, drop_cnt}, 32'd4);
      out_ready = 1'b1;
      exp_trl += 2;
      waitTrailers(exp_trl, 200);
      checkPacket("ovf_p0", 16'hA505, 32'h11112222, 16'h0001, 8, 16'h8008, 1'b1);
      checkPacket("ovf_p1", 16'hA506, 32'h11112222, 16'h0009, 8, 16'h0008, 1'b1);
      checkOutput("ovf_drop_hold", {24'h0, drop_cnt}, 32'd4);

      // Ready toggling every cycle.
      toggle_mode = 1'b1;
      tik_tok     = 32'h0BADF00D;
      writeWords(8, 16'h2000);
      exp_trl++;
      waitTrailers(exp_trl, 200);
      toggle_mode = 1'b0;
      out_ready   = 1'b1;
      checkPacket("toggle", 16'hA507, 32'h0BADF00D, 16'h2000, 8, 16'h0008, 1'b0);

      // Asynchronous reset in the middle of the payload.
      tik_tok = 32'h77778888;
      writeWords(8, 16'h3000);
      for (int i = 0; i < 5; i++) tick();
      checkOutput("mid_valid", {31'h0, out_valid}, 32'h1);
      checkOutput("mid_last", {31'h0, out_last}, 32'h0);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("arst_valid", {31'h0, out_valid}, 32'h0);
      checkOutput("arst_dat", {16'h0, out_dat}, 32'h0);
      checkOutput("arst_last", {31'h0, out_last}, 32'h0);
      checkOutput("arst_drop", {24'h0, drop_cnt}, 32'h0);
      tick();
      rst_n = 1'b1;
      cap_q.delete();
      tick();
      tik_tok = 32'h55AA55AA;
      writeWords(8, 16'h4000);
      exp_trl++;
      waitTrailers(exp_trl, 200);
      checkPacket("post_rst", 16'hA500, 32'h55AA55AA, 16'h4000, 8, 16'h0008, 1'b1);

      // Sequence number wrap across 256 further packets.
      for (int k = 1; k <= 256; k++) begin
         tik_tok = 32'(k);
         writeWords(8, 16'(k * 16));
         exp_trl++;
         waitTrailers(exp_trl, 200);
         checkPacket($sformatf("seq%0d", k), {8'hA5, 8'(k)}, 32'(k), 16'(k * 16), 8, 16'h0008, 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/col_stream_packetizer.md
COL_STREAM_PACKETIZER -- requirements
Module: col_stream_packetizer

Interface
REQ-001 SHALL have parameter PKT_WORDS, default 8, meaning the maximum number of payload words per packet (1..255).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, meaning input FIFO depth in 16-bit words (power of 2, at least PKT_WORDS).
REQ-003 SHALL have parameter TIMEOUT, default 256, meaning IDLE cycles with a non-empty FIFO before a partial packet is flushed.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port in_dat, input, 16 bits: encoded column word from the upstream column encoder.
REQ-007 SHALL have port in_valid, input, 1 bit: one-cycle strobe (the encoder's data_ready) qualifying in_dat; there is no backpressure.
REQ-008 SHALL have port tik_tok, input, 32 bits: free-running timestamp.
REQ-009 SHALL have port out_dat, output, 16 bits: packet word.
REQ-010 SHALL have port out_valid, output, 1 bit: out_dat is valid.
REQ-011 SHALL have port out_ready, input, 1 bit: the downstream sink accepts the word.
REQ-012 SHALL have port out_last, output, 1 bit: high on the trailer word.
REQ-013 SHALL have port drop_cnt, output, 8 bits: saturating count of dropped input words since reset.

Function
REQ-014 SHALL write in_dat into the FIFO on clk when in_valid=1 and the FIFO is not full, with full taken as the registered state before the edge.
REQ-015 SHALL drop a word that arrives while the FIFO is full, even if a read occurs in the same cycle, increment drop_cnt (saturating at 255) and set the sticky flag ovf.
REQ-016 SHALL run the FSM states IDLE -> HDR0 -> HDR1 -> HDR2 -> PAY -> TRL -> IDLE.
REQ-017 SHALL leave IDLE when the FIFO level is at least PKT_WORDS, or when the timeout counter reaches TIMEOUT-1 with the FIFO non-empty.
REQ-018 SHALL, on leaving IDLE, latch nwords = min(level, PKT_WORDS) and ts = tik_tok.
REQ-019 SHALL reset the timeout counter whenever the FSM is not in IDLE or the FIFO is empty.
REQ-020 SHALL assert out_valid with the HDR0 word in the cycle after the IDLE exit edge.
REQ-021 SHALL emit words in this order: HDR0 = {8'hA5, seq[7:0]}, HDR1 = ts[31:16], HDR2 = ts[15:0], then nwords FIFO words in arrival order, then TRL = {ovf, 7'b0, nwords[7:0]} with out_last=1.
REQ-022 SHALL advance each state or word only on out_valid & out_ready.
REQ-023 SHALL hold out_dat and out_last stable while out_valid=1 and out_ready=0, and SHALL never deassert out_valid before acceptance.
REQ-024 SHALL keep out_valid continuously high from HDR0 through TRL (no bubbles), provided out_ready is high.
REQ-025 SHALL, on TRL acceptance, increment seq (255 wraps to 0) and clear ovf; a drop in the same cycle leaves ovf set.
REQ-026 SHALL keep accepting FIFO writes during packet emission; words beyond nwords wait for the next packet.
REQ-027 SHALL drive out_dat=0 and out_last=0 whenever out_valid=0.

Reset
REQ-028 SHALL, while rst_n=0, immediately force out_valid=0, out_dat=0, out_last=0, drop_cnt=0, seq=0, ovf=0, FIFO empty, FSM=IDLE and the timeout counter to 0.
REQ-029 SHALL, on reset mid-packet, abandon the packet without emitting a trailer and lose the FIFO contents.

Structure
REQ-030 SHALL place the SOF byte 8'hA5, the FSM state enum and the default parameter values in the shared package col_pkt_pkg.
REQ-031 SHALL implement the FIFO as the sub-module col_word_fifo: synchronous write/read, registered level, full/empty flags, and first-word fall-through read data.

Verification
REQ-032 SHALL cover: 8 words 0x0001..0x0008 with tik_tok=0x12345678 at trigger and out_ready=1 -> A500,1234,5678,0001..0008,0008 (last), out_valid continuous.
REQ-033 SHALL cover: 3 words then no input -> flush after TIMEOUT idle cycles with HDR0=A501 and TRL=0x0003.
REQ-034 SHALL cover: out_ready=0 during 20 writes -> 16 stored, drop_cnt=4, first TRL=0x8008, next TRL bit15=0.
REQ-035 SHALL cover: out_ready toggled every cycle -> out_dat stable while stalled, no duplicated or missing words.
REQ-036 SHALL cover: rst_n low mid-PAY -> outputs 0 asynchronously, the next packet restarts at A500.
REQ-037 SHALL cover: 257 packets -> HDR0 sequence ...A5FF, A500.
